// File: rtl/pipeline_ifp_stage.sv
// Instruction-fetch-prepare stage: owns the fetch PC, decodes it to the ROM or DRAM channel,
// runs the DRAM request handshake, applies redirects and gates DRAM ready toward IFR.
module pipeline_ifp_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [63:0] ROM_BASE  = 64'h0000_0000_0000_0000,
  parameter logic [63:0] ROM_SIZE  = 64'h0000_0000_0000_1000,
  parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] DRAM_SIZE = 64'h0000_0000_1000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        dram_data_ready,
  output logic [63:0] pc_IFP,
  output logic        if_channel_sel,
  output logic [63:0] rom_addr,
  output logic        dram_req,
  output logic [63:0] dram_addr,
  output logic        fetch_ready,
  output logic        fetch_fault
);

  localparam int          CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_U = TIMEOUT;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [63:0]     pc_reg, pc_next;
  logic [63:0]     drain_addr_reg, drain_addr_next;
  logic            fault_reg, fault_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

  logic            in_rom, in_dram, misaligned, addr_fault, fault_any, timeout_hit;
  logic [63:0]     pc_plus4;

  // Range checks written as offset < size so a region ending at 2^64 cannot overflow.
  assign in_rom      = (pc_reg >= ROM_BASE)  && ((pc_reg - ROM_BASE)  < ROM_SIZE);
  assign in_dram     = (pc_reg >= DRAM_BASE) && ((pc_reg - DRAM_BASE) < DRAM_SIZE);
  assign misaligned  = (pc_reg[1:0] != 2'b00);
  assign addr_fault  = misaligned || !(in_rom || in_dram);
  assign fault_any   = fault_reg || addr_fault;
  assign pc_plus4    = pc_reg + 64'd4;
  // wait_cnt counts cycles the current request has been up, including the issuing cycle.
  assign timeout_hit = ({{(32-CW){1'b0}}, wait_cnt_reg} + 32'd1) >= TIMEOUT_U;

  assign pc_IFP         = pc_reg;
  assign rom_addr       = pc_reg;
  assign if_channel_sel = in_dram;
  assign fetch_fault    = fault_any;
  assign fetch_ready    = dram_data_ready && (state_reg != ST_DRAIN) && !fault_any;

  always_comb begin
    dram_req  = 1'b0;
    dram_addr = 64'd0;
    case (state_reg)
      ST_RUN: begin
        if (in_dram && !fault_any) begin
          dram_req  = 1'b1;
          dram_addr = pc_reg;
        end
      end
      ST_WAIT: begin
        dram_req  = !fault_any;
        dram_addr = fault_any ? 64'd0 : pc_reg;
      end
      ST_DRAIN: begin
        // The abandoned request stays up until memory answers it.
        dram_req  = 1'b1;
        dram_addr = drain_addr_reg;
      end
      default: begin
        dram_req  = 1'b0;
        dram_addr = 64'd0;
      end
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drain_addr_next = drain_addr_reg;
    fault_next      = fault_reg;
    wait_cnt_next   = wait_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_next       = redirect_pc;
          fault_next    = 1'b0;
          wait_cnt_next = '0;
        end else if (fault_any) begin
          fault_next = 1'b1;
        end else if (in_dram) begin
          if (dram_data_ready) begin
            if (!stall) pc_next = pc_plus4;
          end else if (timeout_hit) begin
            fault_next    = 1'b1;
            wait_cnt_next = '0;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = CW'(1);
          end
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_next       = redirect_pc;
          fault_next    = 1'b0;
          wait_cnt_next = '0;
          if (!dram_data_ready) begin
            state_next      = ST_DRAIN;
            drain_addr_next = pc_reg;
          end else begin
            state_next = ST_RUN;
          end
        end else if (fault_any) begin
          fault_next    = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_RUN;
        end else if (dram_data_ready) begin
          if (!stall) begin
            pc_next       = pc_plus4;
            wait_cnt_next = '0;
            state_next    = ST_RUN;
          end
        end else if (timeout_hit) begin
          fault_next    = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_RUN;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      ST_DRAIN: begin
        // A redirect here only retargets the PC; leaving still waits for the stale response.
        if (redirect_valid) begin
          pc_next       = redirect_pc;
          fault_next    = 1'b0;
          wait_cnt_next = '0;
        end
        if (dram_data_ready) state_next = ST_RUN;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      pc_reg         <= RESET_PC;
      drain_addr_reg <= 64'd0;
      fault_reg      <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drain_addr_reg <= drain_addr_next;
      fault_reg      <= fault_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipeline_ifp_stage.sv
// Bench for pipeline_ifp_stage: directed scenarios plus randomized traffic checked every cycle
// against a request-level model of the fetch PC, DRAM handshake and fault rules.
module tb_pipeline_ifp_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dram_data_ready;
  logic [63:0] pc_IFP;
  logic        if_channel_sel;
  logic [63:0] rom_addr;
  logic        dram_req;
  logic [63:0] dram_addr;
  logic        fetch_ready;
  logic        fetch_fault;

  pipeline_ifp_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dram_data_ready(dram_data_ready),
    .pc_IFP         (pc_IFP),
    .if_channel_sel (if_channel_sel),
    .rom_addr       (rom_addr),
    .dram_req       (dram_req),
    .dram_addr      (dram_addr),
    .fetch_ready    (fetch_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  localparam int TIMEOUT = 16;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: PC, sticky fault, whether a DRAM request is outstanding (and its age),
  // and whether an abandoned request is being drained.
  logic [63:0] m_pc, m_drain_addr;
  bit          m_fault, m_out, m_drain;
  int          m_age;

  logic        s_req, s_ready;
  logic [63:0] s_addr;

  function automatic bit in_rom_f(input logic [63:0] a);
    return a < 64'h1000;
  endfunction

  function automatic bit in_dram_f(input logic [63:0] a);
    return (a >= 64'h8000_0000) && (a < 64'h9000_0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_drain_addr = 64'h0;
    m_fault = 0; m_out = 0; m_drain = 0; m_age = 0;
  endtask

  // Called at a negedge: drive inputs, compare outputs, advance the model, wait for next negedge.
  task automatic step(input bit st, input bit rv, input logic [63:0] rp, input bit rdy);
    bit          e_fault, e_req, e_ready, dram;
    logic [63:0] e_addr;
    stall = st; redirect_valid = rv; redirect_pc = rp; dram_data_ready = rdy;
    #1;
    dram    = in_dram_f(m_pc);
    e_fault = m_fault || (m_pc[1:0] != 2'b00) || !(dram || in_rom_f(m_pc));
    e_req   = m_drain ? 1'b1 : (!e_fault && dram);
    e_addr  = m_drain ? m_drain_addr : (e_req ? m_pc : 64'h0);
    e_ready = rdy && !m_drain && !e_fault;
    chk("pc_IFP", pc_IFP, m_pc);
    chk("rom_addr", rom_addr, m_pc);
    chk("if_channel_sel", {63'd0, if_channel_sel}, {63'd0, dram});
    chk("dram_req", {63'd0, dram_req}, {63'd0, e_req});
    chk("dram_addr", dram_addr, e_addr);
    chk("fetch_ready", {63'd0, fetch_ready}, {63'd0, e_ready});
    chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, e_fault});
    s_req = dram_req; s_ready = fetch_ready; s_addr = dram_addr;
    if (m_drain) begin
      if (rv) begin m_pc = rp; m_fault = 0; end
      if (rdy) m_drain = 0;
    end else if (rv) begin
      if (m_out && !rdy) begin m_drain = 1; m_drain_addr = m_pc; end
      m_pc = rp; m_fault = 0; m_out = 0; m_age = 0;
    end else if (e_fault) begin
      m_fault = 1; m_out = 0;
    end else if (dram) begin
      if (rdy) begin
        if (!st) begin m_pc = m_pc + 64'd4; m_out = 0; end
      end else begin
        m_age = m_out ? m_age + 1 : 1;
        m_out = 1;
        if (m_age >= TIMEOUT) begin m_fault = 1; m_out = 0; end
      end
    end else if (!st) begin
      m_pc = m_pc + 64'd4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = 0; dram_data_ready = 0;
    #1;
    chk("async_reset_pc", pc_IFP, 64'h0);
    chk("async_reset_req", {63'd0, dram_req}, 64'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 6))
      0: t = {52'd0, 10'($urandom_range(0, 1023)), 2'b00};
      1: t = 64'hFF8 + 64'(4 * $urandom_range(0, 1));
      2: t = 64'h8000_0000 + 64'(4 * $urandom_range(0, 255));
      3: t = 64'h8FFF_FFF8 + 64'(4 * $urandom_range(0, 1));
      4: t = 64'h8000_0000 + 64'($urandom_range(1, 3));
      5: t = 64'hFFFF_FFFF_FFFF_FFFC;
      default: t = 64'h4000_0000;
    endcase
    return t;
  endfunction

  initial begin
    int req_cnt, rdy_cnt, ready_pct;
    logic [63:0] tgt;
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = 0; dram_data_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // 1: reset state and ROM streaming
    chk("t1_reset_pc", pc_IFP, 64'h0);
    chk("t1_reset_req", {63'd0, dram_req}, 64'd0);
    chk("t1_reset_addr", dram_addr, 64'h0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 64'h0, 0);
      chk("t1_pc", pc_IFP, 64'(4 * i));
    end
    chk("t1_sel", {63'd0, if_channel_sel}, 64'd0);
    $display("T1 rom stream: pc=%h", pc_IFP);

    // 2: DRAM fetch answered on the third request cycle
    step(0, 1, 64'h8000_0000, 0);
    req_cnt = 0; rdy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 64'h0, i == 2);
      req_cnt += int'(s_req); rdy_cnt += int'(s_ready);
    end
    chk("t2_req_cycles", 64'(req_cnt), 64'd3);
    chk("t2_ready_pulses", 64'(rdy_cnt), 64'd1);
    chk("t2_pc", pc_IFP, 64'h8000_0004);
    $display("T2 dram fetch: req_cycles=%0d ready_pulses=%0d pc=%h", req_cnt, rdy_cnt, pc_IFP);

    // 3: redirect while waiting drains the stale response
    step(0, 1, 64'h8000_0010, 0);
    step(0, 0, 64'h0, 0);
    step(0, 0, 64'h0, 0);
    step(0, 1, 64'h100, 0);
    chk("t3_pc_redirect", pc_IFP, 64'h100);
    step(0, 0, 64'h0, 1);
    chk("t3_drain_ready", {63'd0, s_ready}, 64'd0);
    chk("t3_drain_addr", s_addr, 64'h8000_0010);
    chk("t3_pc_after_drain", pc_IFP, 64'h100);
    step(0, 0, 64'h0, 0);
    chk("t3_pc_next", pc_IFP, 64'h104);
    $display("T3 drain: pc=%h", pc_IFP);

    // 4: stall holds the ROM PC
    step(0, 1, 64'h20, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 64'h0, 0);
      chk("t4_pc_stalled", pc_IFP, 64'h20);
    end
    step(0, 0, 64'h0, 0);
    chk("t4_pc_release", pc_IFP, 64'h24);
    $display("T4 stall: pc=%h", pc_IFP);

    // 5: misaligned redirect faults, a good redirect clears it
    step(0, 1, 64'h102, 0);
    chk("t5_fault", {63'd0, fetch_fault}, 64'd1);
    step(0, 0, 64'h0, 0);
    chk("t5_pc_hold", pc_IFP, 64'h102);
    step(0, 1, 64'h200, 0);
    chk("t5_fault_clear", {63'd0, fetch_fault}, 64'd0);
    chk("t5_pc", pc_IFP, 64'h200);
    $display("T5 misaligned: pc=%h fault=%0b", pc_IFP, fetch_fault);

    // 6: DRAM never answers -> timeout fault
    step(0, 1, 64'h8000_0100, 0);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 64'h0, 0);
      req_cnt += int'(s_req);
    end
    chk("t6_req_cycles", 64'(req_cnt), 64'(TIMEOUT));
    chk("t6_fault", {63'd0, fetch_fault}, 64'd1);
    chk("t6_req_dropped", {63'd0, dram_req}, 64'd0);
    $display("T6 timeout: req_cycles=%0d fault=%0b", req_cnt, fetch_fault);
    step(0, 1, 64'h0, 0);

    // Randomized traffic
    ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ready_pct = (ready_pct == 50) ? 5 : 50;
      if (c == 1500) begin
        do_reset();
        $display("RND reset at cycle %0d", c);
      end
      if ($urandom_range(0, 99) < 5) begin
        tgt = pick_target();
        $display("RND cycle %0d redirect to %h", c, tgt);
        step($urandom_range(0, 99) < 20, 1, tgt, $urandom_range(0, 99) < ready_pct);
      end else begin
        step($urandom_range(0, 99) < 20, 0, 64'h0, $urandom_range(0, 99) < ready_pct);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
